// File: rtl/gf_mult_serial.sv
// Digit-serial GF(2^NB_BYTE) multiplier: product = a * b mod (x^NB_BYTE + M_X).
// Consumes NB_DIGIT bits of b per clock, MSB first, via unrolled Horner steps.
//
// state | meaning
// IDLE  | waiting for operands, o_ready high
// CALC  | Horner accumulation in progress, o_busy high
module gf_mult_serial #(
  parameter int                 NB_BYTE  = 8,
  parameter logic [NB_BYTE-1:0] M_X      = 8'h1b,
  parameter int                 NB_DIGIT = 1
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [NB_BYTE-1:0] i_a,
  input  logic [NB_BYTE-1:0] i_b,
  output logic               o_ready,
  output logic               o_valid,
  output logic [NB_BYTE-1:0] o_product,
  output logic               o_busy
);

  localparam int SAFE_DIGIT = (NB_DIGIT < 1) ? 1 : NB_DIGIT;
  localparam bit BAD_CONF   = (NB_DIGIT < 1) || ((NB_BYTE % SAFE_DIGIT) != 0);
  // Unsupported configurations collapse to a single step rather than failing elaboration.
  localparam int N_STEPS    = BAD_CONF ? 1 : NB_BYTE / SAFE_DIGIT;
  localparam int CW         = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_STEPS - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state_q, state_d;
  logic [NB_BYTE-1:0] a_q, b_q, acc_q;
  logic [NB_BYTE-1:0] acc_d, b_d;
  logic [CW-1:0]      cnt_q;
  logic [NB_BYTE-1:0] product_q;
  logic               valid_q;
  logic               accept, last_step;

  function automatic logic [NB_BYTE-1:0] xtime(input logic [NB_BYTE-1:0] v);
    return {v[NB_BYTE-2:0], 1'b0} ^ (v[NB_BYTE-1] ? M_X : '0);
  endfunction

  assign accept    = (state_q == IDLE) && i_valid && !i_clear;
  assign last_step = (state_q == CALC) && (cnt_q == LAST);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (i_clear || last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == IDLE);
    o_busy  = (state_q == CALC);
  end

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    for (int i = 0; i < NB_DIGIT; i++) begin
      acc_d = xtime(acc_d) ^ (b_d[NB_BYTE-1] ? a_q : '0);
      b_d   = {b_d[NB_BYTE-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        a_q   <= i_a;
        b_q   <= i_b;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == CALC && !i_clear) begin
        acc_q <= acc_d;
        b_q   <= b_d;
        cnt_q <= cnt_q + CW'(1);
        // An abort on the completion edge discards the result entirely.
        if (last_step) begin
          product_q <= acc_d;
          valid_q   <= 1'b1;
        end
      end
    end
  end

  assign o_valid   = valid_q;
  assign o_product = product_q;

endmodule

// File: tb/tb_gf_mult_serial.sv
// Bench for gf_mult_serial: per-cycle comparison of the default instance against a
// latency/product model, plus directed vectors on digit-width and small-field variants.
module tb_gf_mult_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       ready, ovalid, busy;
  logic [7:0] product;

  logic       aux_valid = 1'b0;
  logic       aux_clear = 1'b0;
  logic [7:0] aux_a = 8'h00, aux_b = 8'h00;
  logic [3:0] s_a = 4'h0, s_b = 4'h0;
  logic       d2_ready, d2_valid, d2_busy;
  logic       d4_ready, d4_valid, d4_busy;
  logic       d8_ready, d8_valid, d8_busy;
  logic       sm_ready, sm_valid, sm_busy;
  logic [7:0] d2_prod, d4_prod, d8_prod;
  logic [3:0] sm_prod;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gf_mult_serial dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_clear(clear), .i_valid(valid),
    .i_a(a), .i_b(b), .o_ready(ready), .o_valid(ovalid), .o_product(product), .o_busy(busy)
  );
  gf_mult_serial #(.NB_DIGIT(2)) dut_d2 (
    .i_clock(clk), .i_reset_n(rst_n), .i_clear(aux_clear), .i_valid(aux_valid),
    .i_a(aux_a), .i_b(aux_b), .o_ready(d2_ready), .o_valid(d2_valid), .o_product(d2_prod), .o_busy(d2_busy)
  );
  gf_mult_serial #(.NB_DIGIT(4)) dut_d4 (
    .i_clock(clk), .i_reset_n(rst_n), .i_clear(aux_clear), .i_valid(aux_valid),
    .i_a(aux_a), .i_b(aux_b), .o_ready(d4_ready), .o_valid(d4_valid), .o_product(d4_prod), .o_busy(d4_busy)
  );
  gf_mult_serial #(.NB_DIGIT(8)) dut_d8 (
    .i_clock(clk), .i_reset_n(rst_n), .i_clear(aux_clear), .i_valid(aux_valid),
    .i_a(aux_a), .i_b(aux_b), .o_ready(d8_ready), .o_valid(d8_valid), .o_product(d8_prod), .o_busy(d8_busy)
  );
  gf_mult_serial #(.NB_BYTE(4), .M_X(4'h3), .NB_DIGIT(1)) dut_sm (
    .i_clock(clk), .i_reset_n(rst_n), .i_clear(aux_clear), .i_valid(aux_valid),
    .i_a(s_a), .i_b(s_b), .o_ready(sm_ready), .o_valid(sm_valid), .o_product(sm_prod), .o_busy(sm_busy)
  );

  // Field product as carry-less multiply followed by polynomial long division.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y,
                                      input int nb, input logic [7:0] mx);
    logic [15:0] p;
    logic [15:0] poly;
    p = '0;
    for (int i = 0; i < nb; i++)
      if (y[i]) p = p ^ (16'(x) << i);
    poly = (16'(1) << nb) | 16'(mx);
    for (int i = 2 * nb - 2; i >= nb; i--)
      if (p[i]) p = p ^ (poly << (i - nb));
    return p[7:0];
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of the default instance: remaining cycles until the result appears.
  int         m_left;
  logic       m_valid;
  logic [7:0] m_prod, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_valid <= 1'b0;
      m_prod  <= 8'h00;
      m_pend  <= 8'h00;
    end else begin
      m_valid <= 1'b0;
      if (m_left != 0) begin
        if (clear) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_valid <= 1'b1;
            m_prod  <= m_pend;
          end
        end
      end else if (valid && !clear) begin
        m_pend <= gmul(a, b, 8, 8'h1b);
        m_left <= 8;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_ready", ready, m_left == 0);
      chk("cyc_busy", busy, m_left != 0);
      chk("cyc_valid", ovalid, m_valid);
      chk("cyc_product", product, m_prod);
    end
  end

  task automatic wait_done(output int lat, output logic [7:0] p);
    lat = -1;
    p   = 8'hxx;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (ovalid) begin
        lat = n;
        p   = product;
        return;
      end
    end
  endtask

  task automatic start_op(input logic [7:0] x, input logic [7:0] y);
    @(posedge clk); #1;
    valid = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] exp);
    int         lat;
    logic [7:0] p;
    start_op(x, y);
    wait_done(lat, p);
    chk({name, "_lat"}, lat, 8);
    chk(name, p, exp);
  endtask

  task automatic aux_run(input logic [7:0] x, input logic [7:0] y, input logic [7:0] exp8,
                         input logic [3:0] sx, input logic [3:0] sy, input logic [3:0] exp4);
    int         lat[4];
    logic [7:0] pr[4];
    for (int k = 0; k < 4; k++) begin lat[k] = -1; pr[k] = 8'hxx; end
    @(posedge clk); #1;
    aux_valid = 1'b1; aux_a = x; aux_b = y; s_a = sx; s_b = sy;
    @(posedge clk); #1;
    aux_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (d2_valid && lat[0] < 0) begin lat[0] = n; pr[0] = d2_prod; end
      if (d4_valid && lat[1] < 0) begin lat[1] = n; pr[1] = d4_prod; end
      if (d8_valid && lat[2] < 0) begin lat[2] = n; pr[2] = d8_prod; end
      if (sm_valid && lat[3] < 0) begin lat[3] = n; pr[3] = {4'h0, sm_prod}; end
    end
    chk("d2_lat", lat[0], 4);
    chk("d4_lat", lat[1], 2);
    chk("d8_lat", lat[2], 1);
    chk("small_lat", lat[3], 4);
    chk("d2_prod", pr[0], exp8);
    chk("d4_prod", pr[1], exp8);
    chk("d8_prod", pr[2], exp8);
    chk("small_prod", pr[3], {4'h0, exp4});
    chk("aux_idle", {d2_ready, d4_ready, d8_ready, sm_ready, d2_busy, d4_busy, d8_busy, sm_busy}, 8'hF0);
  endtask

  initial begin
    int         lat;
    int         pulses, first_n, second_n;
    logic [7:0] p, xt, rx, ry;

    chk("model_57x83", gmul(8'h57, 8'h83, 8, 8'h1b), 8'hC1);
    chk("model_57x13", gmul(8'h57, 8'h13, 8, 8'h1b), 8'hFE);
    chk("model_80x02", gmul(8'h80, 8'h02, 8, 8'h1b), 8'h1B);
    chk("model_9x7_gf16", gmul(8'h09, 8'h07, 4, 8'h03), 8'h0A);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_valid", ovalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    rst_n = 1'b1;

    do_op("fips_57x83", 8'h57, 8'h83, 8'hC1);
    do_op("fips_57x13", 8'h57, 8'h13, 8'hFE);
    do_op("x80_x02", 8'h80, 8'h02, 8'h1B);
    do_op("xff_x01", 8'hFF, 8'h01, 8'hFF);
    do_op("zero_a", 8'h00, 8'hA5, 8'h00);
    do_op("zero_b", 8'hA5, 8'h00, 8'h00);

    for (int x = 0; x < 256; x++) begin
      rx = 8'(x);
      xt = {rx[6:0], 1'b0} ^ (rx[7] ? 8'h1b : 8'h00);
      do_op("times03", rx, 8'h03, xt ^ rx);
    end

    for (int k = 0; k < 30; k++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      do_op("random", rx, ry, gmul(rx, ry, 8, 8'h1b));
    end

    // Continuous i_valid: accepts every 9 cycles.
    @(posedge clk); #1;
    valid = 1'b1; a = 8'h57; b = 8'h83;
    pulses = 0; first_n = -1; second_n = -1;
    for (int n = 0; n < 27; n++) begin
      @(posedge clk); #1;
      if (ovalid) begin
        pulses++;
        if (first_n < 0) first_n = n;
        else if (second_n < 0) second_n = n;
      end
    end
    valid = 1'b0;
    chk("hold_pulses", pulses, 3);
    chk("hold_first", first_n, 8);
    chk("hold_spacing", second_n - first_n, 9);

    // Operands offered while busy are not captured.
    @(posedge clk); #1;
    valid = 1'b1; a = 8'h57; b = 8'h83;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid = 1'b0;
    wait_done(lat, p);
    chk("busy_ignore_lat", lat, 6);
    chk("busy_ignore_prod", p, 8'hC1);

    // Abort in the third CALC cycle.
    start_op(8'h12, 8'h34);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_ready", ready, 1);
    chk("clr_busy", busy, 0);
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (ovalid) pulses++;
    end
    chk("clr_no_valid", pulses, 0);
    chk("clr_prod_kept", product, 8'hC1);
    do_op("after_clr", 8'h57, 8'h13, 8'hFE);

    // Abort exactly on the completion edge.
    start_op(8'h02, 8'h03);
    repeat (7) begin @(posedge clk); #1; end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_last_valid", ovalid, 0);
    chk("clr_last_prod", product, 8'hFE);
    chk("clr_last_ready", ready, 1);

    // i_clear beats i_valid in IDLE.
    @(posedge clk); #1;
    valid = 1'b1; clear = 1'b1; a = 8'h57; b = 8'h83;
    @(posedge clk); #1;
    valid = 1'b0; clear = 1'b0;
    chk("clr_idle_busy", busy, 0);
    chk("clr_idle_ready", ready, 1);

    // Reset mid-operation.
    start_op(8'h57, 8'h83);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", ready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", ovalid, 0);
    chk("rst_mid_product", product, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op("after_rst", 8'h57, 8'h83, 8'hC1);

    aux_run(8'h57, 8'h83, 8'hC1, 4'h9, 4'h7, 4'hA);
    for (int k = 0; k < 6; k++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      aux_run(rx, ry, gmul(rx, ry, 8, 8'h1b), rx[3:0], ry[3:0],
              4'(gmul({4'h0, rx[3:0]}, {4'h0, ry[3:0]}, 4, 8'h03)));
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
